// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle logic/arith, bit-serial shifts, shift-add multiply; 1..WIDTH cycles.
// Start is accepted only while Busy=0; Busy covers the Done cycle, so a Start coincident with Done is dropped.
module alu_seq_unit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic             WF,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       Flags,
   output logic             Busy,
   output logic             Done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic [2:0]       op_q;
   logic             wf_q;
   logic [CNT_W-1:0] cnt, cnt_load;
   logic             accept, last;

   logic [WIDTH:0]   add_s, sub_s, mul_s;
   logic [WIDTH-1:0] res, step_acc, step_b;
   logic             c_new, c_upd, o_new, o_upd;

   assign accept = (state == IDLE) && !Done && Start;
   assign last   = (state == EXEC) && (cnt == CNT_W'(1));
   assign Busy   = (state == EXEC) || Done;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_load = CNT_W'(1);
      if (Op == OP_MUL)
         cnt_load = CNT_W'(WIDTH);
      else if ((Op == OP_LSL || Op == OP_LSR) && B[3:0] != 4'd0)
         cnt_load = CNT_W'(B[3:0]);
   end

   // Shifts and MUL advance one step per EXEC cycle; the step taken on the last cycle is the result.
   always_comb begin
      add_s    = {1'b0, a_q} + {1'b0, b_q};
      sub_s    = {1'b0, a_q} - {1'b0, b_q};
      mul_s    = {1'b0, acc} + (b_q[0] ? {1'b0, a_q} : '0);
      res      = '0;
      step_acc = acc;
      step_b   = b_q;
      c_new    = 1'b0;
      c_upd    = 1'b0;
      o_new    = 1'b0;
      o_upd    = 1'b0;
      case (op_q)
         OP_ADD: begin
            res   = add_s[WIDTH-1:0];
            c_new = add_s[WIDTH];
            c_upd = 1'b1;
            o_new = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            o_upd = 1'b1;
         end
         OP_SUB: begin
            res   = sub_s[WIDTH-1:0];
            c_new = ~sub_s[WIDTH];
            c_upd = 1'b1;
            o_new = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
            o_upd = 1'b1;
         end
         OP_AND: res = a_q & b_q;
         OP_OR:  res = a_q | b_q;
         OP_XOR: res = a_q ^ b_q;
         OP_LSL: begin
            if (b_q[3:0] != 4'd0) begin
               step_acc = {acc[WIDTH-2:0], 1'b0};
               c_new    = acc[WIDTH-1];
               c_upd    = 1'b1;
            end
            res = step_acc;
         end
         OP_LSR: begin
            if (b_q[3:0] != 4'd0) begin
               step_acc = {1'b0, acc[WIDTH-1:1]};
               c_new    = acc[0];
               c_upd    = 1'b1;
            end
            res = step_acc;
         end
         OP_MUL: begin
            // acc holds the upper product half, b_q shifts out multiplier bits and fills with the lower half
            step_acc = mul_s[WIDTH:1];
            step_b   = {mul_s[0], b_q[WIDTH-1:1]};
            res      = step_b;
            c_new    = |step_acc;
            c_upd    = 1'b1;
         end
         default: res = '0;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         op_q   <= OP_ADD;
         wf_q   <= 1'b0;
         cnt    <= '0;
         ALUOut <= '0;
         Flags  <= '0;
         Done   <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= Op;
            wf_q <= WF;
            acc  <= (Op == OP_MUL) ? '0 : A;
            cnt  <= cnt_load;
         end else if (state == EXEC) begin
            acc <= step_acc;
            b_q <= step_b;
            cnt <= cnt - CNT_W'(1);
            if (last) begin
               ALUOut <= res;
               Done   <= 1'b1;
               if (wf_q)
                  Flags <= {(res == '0), (c_upd ? c_new : Flags[2]),
                            res[WIDTH-1], (o_upd ? o_new : Flags[0])};
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed + random bench for alu_seq_unit; a queue scoreboard holds result, flags and Done cycle per accepted op.
module tb_alu_seq_unit;
   localparam int W = 16;

   logic         Clock = 1'b0;
   logic         Reset, Start, WF, Busy, Done;
   logic [2:0]   Op;
   logic [W-1:0] A, B, ALUOut;
   logic [3:0]   Flags;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [W-1:0] out;
      logic [3:0]   fl;
      int           done_cyc;
   } exp_t;

   exp_t       q[$];
   logic [3:0] mf;
   logic [3:0] saved_fl;

   alu_seq_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .WF(WF),
      .A(A), .B(B), .ALUOut(ALUOut), .Flags(Flags), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word arithmetic, flags {Z,C,N,O}
   function automatic logic [19:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic wf, input logic [3:0] fl);
      logic [W:0]     s;
      logic [2*W-1:0] p;
      logic [W-1:0]   r;
      logic           c, o;
      int             n;
      c = fl[2];
      o = fl[0];
      n = int'(b[3:0]);
      r = '0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            r = a - b;
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin
            r = a << n;
            if (n > 0) c = a[W-n];
         end
         3'd6: begin
            r = a >> n;
            if (n > 0) c = a[n-1];
         end
         default: begin
            p = (2*W)'(a) * (2*W)'(b);
            r = p[W-1:0];
            c = |p[2*W-1:W];
         end
      endcase
      return wf ? {r, (r == '0), c, r[W-1], o} : {r, fl};
   endfunction

   function automatic int lat(input logic [2:0] op, input logic [W-1:0] b);
      if (op == 3'd7) return W;
      if ((op == 3'd5 || op == 3'd6) && b[3:0] != 4'd0) return int'(b[3:0]);
      return 1;
   endfunction

   always @(negedge Clock) begin : mon
      exp_t e;
      if (Done) begin
         check("done_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("aluout", 32'(ALUOut), 32'(e.out));
            check("flags", 32'(Flags), 32'(e.fl));
            check("latency", 32'(cyc), 32'(e.done_cyc));
            check("busy_at_done", 32'(Busy), 32'd1);
         end
      end
   end

   // Called at a negedge with the unit idle; returns one negedge later with operands scrambled.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic wf);
      exp_t        e;
      logic [19:0] m;
      m          = model(op, a, b, wf, mf);
      mf         = m[3:0];
      e.out      = m[19:4];
      e.fl       = m[3:0];
      e.done_cyc = cyc + 1 + lat(op, b);
      q.push_back(e);
      Start = 1'b1; Op = op; A = a; B = b; WF = wf;
      @(negedge Clock);
      Start = 1'b0;
      A = 16'($urandom); B = 16'($urandom); Op = 3'($urandom); WF = 1'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int budget = 40;
      while (q.size() != 0 && budget > 0) begin
         @(negedge Clock);
         budget--;
      end
      check({tag, "_timeout"}, 32'(q.size()), 32'd0);
      if (q.size() != 0) q.delete();
      @(negedge Clock);
      check({tag, "_idle"}, 32'(Busy), 32'd0);
   endtask

   task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic wf,
                      input string tag);
      issue(op, a, b, wf);
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      wait_idle(tag);
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; WF = 1'b0;
      mf = '0;
      repeat (2) @(negedge Clock);
      check("rst_aluout", 32'(ALUOut), 32'd0);
      check("rst_flags", 32'(Flags), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      Reset = 1'b1;
      @(negedge Clock);

      run(3'd0, 16'h7FFF, 16'h0001, 1'b1, "add_ovf");
      check("add_ovf_out", 32'(ALUOut), 32'h8000);
      check("add_ovf_fl", 32'(Flags), 32'b0011);
      run(3'd1, 16'h0005, 16'h0005, 1'b1, "sub_zero");
      check("sub_zero_out", 32'(ALUOut), 32'h0000);
      check("sub_zero_fl", 32'(Flags), 32'b1100);
      run(3'd5, 16'h8001, 16'h0003, 1'b1, "lsl3");
      check("lsl3_out", 32'(ALUOut), 32'h0008);
      check("lsl3_c", 32'(Flags[2]), 32'd0);
      run(3'd5, 16'h8001, 16'h0001, 1'b1, "lsl1");
      check("lsl1_out", 32'(ALUOut), 32'h0002);
      check("lsl1_c", 32'(Flags[2]), 32'd1);
      run(3'd6, 16'h8001, 16'h0000, 1'b1, "lsr0");
      check("lsr0_out", 32'(ALUOut), 32'h8001);
      run(3'd6, 16'h8001, 16'h000F, 1'b1, "lsr15");
      run(3'd7, 16'h0100, 16'h0100, 1'b1, "mul_big");
      check("mul_big_out", 32'(ALUOut), 32'h0000);
      check("mul_big_zc", 32'(Flags[3:2]), 32'b11);
      run(3'd1, 16'h0003, 16'h0005, 1'b1, "sub_borrow");

      // ADD offered two cycles into a MUL must be dropped
      issue(3'd7, 16'h0003, 16'h0005, 1'b1);
      @(negedge Clock);
      Start = 1'b1; Op = 3'd0; A = 16'h0001; B = 16'h0001; WF = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      wait_idle("mul_busy");
      check("mul_small_out", 32'(ALUOut), 32'h000F);
      check("mul_small_c", 32'(Flags[2]), 32'd0);

      saved_fl = Flags;
      run(3'd2, 16'hF0F0, 16'h0000, 1'b0, "and_nowf");
      check("and_nowf_out", 32'(ALUOut), 32'h0000);
      check("and_nowf_fl", 32'(Flags), 32'(saved_fl));

      // Start raised during the Done cycle must be dropped
      issue(3'd4, 16'h00FF, 16'h0F0F, 1'b1);
      @(negedge Clock);
      check("done_cycle_seen", 32'(Done), 32'd1);
      Start = 1'b1; Op = 3'd3; A = 16'h1234; B = 16'h4321; WF = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (3) @(negedge Clock);
      check("done_cycle_idle", 32'(Busy), 32'd0);
      check("done_cycle_out", 32'(ALUOut), 32'h0FF0);

      for (int i = 0; i < 24; i++)
         run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rand");

      run(3'd0, 16'h7FFF, 16'h0001, 1'b1, "pre_rst");
      issue(3'd7, 16'h1234, 16'h0567, 1'b1);
      repeat (7) @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_out", 32'(ALUOut), 32'd0);
      check("midrst_flags", 32'(Flags), 32'd0);
      check("midrst_done", 32'(Done), 32'd0);
      q.delete();
      mf = '0;
      repeat (20) @(negedge Clock);
      Reset = 1'b1;
      repeat (20) @(negedge Clock);
      check("post_rst_nodone_out", 32'(ALUOut), 32'd0);
      run(3'd1, 16'h0003, 16'h0005, 1'b1, "post_rst");
      check("post_rst_out", 32'(ALUOut), 32'hFFFE);
      check("post_rst_fl", 32'(Flags), 32'b0010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
